// File: rtl/seqcheck_ctrl_if.sv
// Handshake/data bundle between the serial front end and the pattern-check sequencer.
// The master side supplies config and serial bits; the slave side returns status and results.
interface seqcheck_ctrl_if #(
    parameter int W    = 7,
    parameter int CNTW = 8,
    parameter int MW   = 8
);
    logic            start;
    logic [W-1:0]    pat;
    logic [W-1:0]    mask;
    logic [CNTW-1:0] frame_len;
    logic            in;
    logic            in_vld;
    logic            busy;
    logic            done;
    logic            hit;
    logic [MW-1:0]   match_cnt;
    logic            overflow;

    modport master (
        output start, pat, mask, frame_len, in, in_vld,
        input  busy, done, hit, match_cnt, overflow
    );

    modport slave (
        input  start, pat, mask, frame_len, in, in_vld,
        output busy, done, hit, match_cnt, overflow
    );
endinterface

// File: rtl/seqcheck_ctrl.sv
// Sequencer for the serial pattern checker: arms on start, scans frame_len valid bits
// through a W-bit window, and reports per-match hit pulses, a saturating count and a done pulse.
module seqcheck_ctrl #(
    parameter int W    = 7,
    parameter int CNTW = 8,
    parameter int MW   = 8
) (
    input logic            clk,
    input logic            rst,
    seqcheck_ctrl_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [MW-1:0] CNT_MAX = '1;
    localparam logic [CNTW:0] W_EXT   = (CNTW + 1)'(W);

    logic [1:0]      state;
    logic [W-1:0]    hist;
    logic [W-1:0]    pat_l;
    logic [W-1:0]    mask_l;
    logic [CNTW-1:0] frame_len_l;
    logic [CNTW-1:0] bitcnt;

    logic            busy;
    logic            done;
    logic            hit;
    logic [MW-1:0]   match_cnt;
    logic            overflow;

    logic [W-1:0]    window;
    logic [CNTW:0]   bitcnt_nx;
    logic            match;
    logic            last_bit;
    logic            cnt_sat;

    // bitcnt_nx carries an extra bit so the compare against W and frame_len never wraps
    always_comb begin
        window    = {hist[W-2:0], bus.in};
        bitcnt_nx = {1'b0, bitcnt} + (CNTW + 1)'(1);
        match     = (((window ^ pat_l) & mask_l) == '0) && (bitcnt_nx >= W_EXT);
        last_bit  = (bitcnt_nx == {1'b0, frame_len_l});
        cnt_sat   = (match_cnt == CNT_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            hist        <= '0;
            pat_l       <= '0;
            mask_l      <= '0;
            frame_len_l <= '0;
            bitcnt      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit         <= 1'b0;
            match_cnt   <= '0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    hit  <= 1'b0;
                    done <= 1'b0;
                    if (bus.start) begin
                        pat_l       <= bus.pat;
                        mask_l      <= bus.mask;
                        frame_len_l <= bus.frame_len;
                        hist        <= '0;
                        bitcnt      <= '0;
                        match_cnt   <= '0;
                        overflow    <= 1'b0;
                        busy        <= 1'b1;
                        if (bus.frame_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (bus.in_vld) begin
                        hist   <= window;
                        bitcnt <= bitcnt_nx[CNTW-1:0];
                        hit    <= match;
                        if (match) begin
                            if (cnt_sat) overflow  <= 1'b1;
                            else         match_cnt <= match_cnt + MW'(1);
                        end
                        // done is raised on the same edge that samples the last bit
                        if (last_bit) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        hit <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    hit   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    hit   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.hit       = hit;
    assign bus.match_cnt = match_cnt;
    assign bus.overflow  = overflow;
endmodule

// File: tb/tb_seqcheck_ctrl.sv
// Directed bench for seqcheck_ctrl: one vector table plus hand sequences for stalls,
// masking, saturation, empty frames and ignored starts.
module tb_seqcheck_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seqcheck_ctrl_if #(.W(7), .CNTW(8), .MW(8)) b8 ();
    seqcheck_ctrl_if #(.W(7), .CNTW(8), .MW(2)) b2 ();

    seqcheck_ctrl #(.W(7), .CNTW(8), .MW(8)) dut8 (.clk(clk), .rst(rst), .bus(b8));
    seqcheck_ctrl #(.W(7), .CNTW(8), .MW(2)) dut2 (.clk(clk), .rst(rst), .bus(b2));

    assign b2.start     = b8.start;
    assign b2.pat       = b8.pat;
    assign b2.mask      = b8.mask;
    assign b2.frame_len = b8.frame_len;
    assign b2.in        = b8.in;
    assign b2.in_vld    = b8.in_vld;

    typedef struct {
        logic       r, s, d, v;
        logic [6:0] p, m;
        logic [7:0] fl;
        logic       busy, done, hit;
        logic [7:0] cnt;
        logic       ovf;
    } vec_t;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_err = 0;

    localparam logic [6:0] PA = 7'b1010101;
    localparam logic [6:0] MA = 7'h7F;

    logic       str_a [10] = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
    logic       hit_a [10] = '{0, 0, 0, 0, 0, 0, 1, 0, 1, 0};
    logic [7:0] cnt_a [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 2, 2};
    logic       str_c [14] = '{0, 1, 0, 1, 0, 1, 1, 0, 1, 0, 1, 0, 1, 0};
    logic       hit_c [14] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};
    logic [7:0] cnt_c [14] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 2};

    function automatic vec_t mk(input logic r, s, d, v, input logic [6:0] p, m,
                                input logic [7:0] fl, input logic eb, ed, eh,
                                input logic [7:0] ec, input logic eo);
        vec_t x;
        x.r = r; x.s = s; x.d = d; x.v = v; x.p = p; x.m = m; x.fl = fl;
        x.busy = eb; x.done = ed; x.hit = eh; x.cnt = ec; x.ovf = eo;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cfg(input logic [6:0] p, input logic [6:0] m, input logic [7:0] fl);
        b8.pat = p; b8.mask = m; b8.frame_len = fl;
    endtask

    task automatic drive(input logic r, input logic s, input logic d, input logic v);
        rst = r; b8.start = s; b8.in = d; b8.in_vld = v;
        @(posedge clk);
        #1;
    endtask

    task automatic exp8(input string nm, input logic eb, input logic ed, input logic eh,
                        input logic [7:0] ec, input logic eo);
        chk({nm, ".busy"}, 32'(b8.busy), 32'(eb));
        chk({nm, ".done"}, 32'(b8.done), 32'(ed));
        chk({nm, ".hit"},  32'(b8.hit),  32'(eh));
        chk({nm, ".cnt"},  32'(b8.match_cnt), 32'(ec));
        chk({nm, ".ovf"},  32'(b8.overflow), 32'(eo));
    endtask

    task automatic exp2(input string nm, input logic eb, input logic ed, input logic eh,
                        input logic [1:0] ec, input logic eo);
        chk({nm, ".busy2"}, 32'(b2.busy), 32'(eb));
        chk({nm, ".done2"}, 32'(b2.done), 32'(ed));
        chk({nm, ".hit2"},  32'(b2.hit),  32'(eh));
        chk({nm, ".cnt2"},  32'(b2.match_cnt), 32'(ec));
        chk({nm, ".ovf2"},  32'(b2.overflow), 32'(eo));
    endtask

    initial begin
        int   b;
        int   n_done;
        logic [7:0] ec;
        rst = 1'b1; b8.start = 1'b0; b8.in = 1'b0; b8.in_vld = 1'b0;
        cfg('0, '0, '0);

        // reset, a full 10-bit frame, idle hold, then reset in the middle of a frame
        tbl.push_back(mk(1, 0, 0, 0, PA, MA, 10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 1, 0, 1, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, PA, MA, 10, 1, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 1, 0, 1, 2, 0));
        tbl.push_back(mk(0, 0, 0, 1, PA, MA, 10, 1, 1, 0, 2, 0));
        tbl.push_back(mk(0, 0, 0, 0, PA, MA, 10, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 1, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 1, 1, PA, MA, 10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, PA, MA, 10, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, PA, MA, 10, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            cfg(tbl[i].p, tbl[i].m, tbl[i].fl);
            drive(tbl[i].r, tbl[i].s, tbl[i].d, tbl[i].v);
            exp8($sformatf("vec%0d", i), tbl[i].busy, tbl[i].done, tbl[i].hit,
                 tbl[i].cnt, tbl[i].ovf);
        end

        // same frame with in_vld toggling: stall cycles hold state and never hit
        cfg(PA, MA, 10);
        drive(0, 1, 0, 0);
        exp8("B.start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            b = i / 2;
            if (i % 2 == 0) begin
                drive(0, 0, str_a[b], 1);
                exp8($sformatf("B.bit%0d", b + 1), 1, b == 9, hit_a[b], cnt_a[b], 0);
            end else begin
                drive(0, 0, 1, 0);
                exp8($sformatf("B.stall%0d", b + 1), b != 9, 0, 0, cnt_a[b], 0);
            end
        end

        // newest bit masked out
        cfg(7'b0101010, 7'b1111110, 14);
        drive(0, 1, 0, 0);
        exp8("C.start", 1, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            drive(0, 0, str_c[i], 1);
            exp8($sformatf("C.bit%0d", i + 1), 1, i == 13, hit_c[i], cnt_c[i], 0);
        end
        drive(0, 0, 0, 0);
        exp8("C.idle", 0, 0, 0, 2, 0);

        // empty frame closes immediately and clears the previous count
        cfg(PA, MA, 0);
        drive(0, 1, 0, 0);
        exp8("E.start", 1, 1, 0, 0, 0);
        drive(0, 0, 1, 1);
        exp8("E.after", 0, 0, 0, 0, 0);

        // mask=0: every bit from the 7th matches; MW=2 saturates at 3 then flags overflow
        cfg(PA, 7'h00, 12);
        drive(0, 1, 0, 0);
        exp2("D.start", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 12; i++) begin
            drive(0, 0, i[0], 1);
            exp2($sformatf("D.bit%0d", i), 1, i == 12, i >= 7,
                 (i < 7) ? 2'd0 : (i == 7) ? 2'd1 : (i == 8) ? 2'd2 : 2'd3, i >= 10);
            ec = (i < 7) ? 8'd0 : 8'(i - 6);
            chk($sformatf("D.bit%0d.cnt8", i), 32'(b8.match_cnt), 32'(ec));
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 1, 1);
            exp2($sformatf("D.hold%0d", i), 0, 0, 0, 3, 1);
        end
        // frame shorter than the window never matches even with mask=0
        cfg(PA, 7'h00, 5);
        drive(0, 1, 0, 0);
        exp2("D2.start", 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 1, 1);
            exp2($sformatf("D2.bit%0d", i), 1, i == 5, 0, 0, 0);
        end
        drive(0, 0, 0, 0);
        exp2("D2.idle", 0, 0, 0, 0, 0);

        // starts during RUN and during DONE are dropped, not queued
        cfg(PA, MA, 10);
        drive(0, 1, 0, 0);
        exp8("F.start", 1, 0, 0, 0, 0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            drive(0, i == 3, str_a[i], 1);
            if (b8.done) n_done++;
        end
        chk("F.cnt", 32'(b8.match_cnt), 32'd2);
        cfg(PA, MA, 0);
        drive(0, 1, 0, 0);
        exp8("F.done_start", 0, 0, 0, 2, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0, 0, 1, 1);
            if (b8.done) n_done++;
            chk($sformatf("F.busy%0d", i), 32'(b8.busy), 32'd0);
        end
        chk("F.n_done", 32'(n_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seqcheck_ctrl.md
# seqcheck_ctrl

Controller and sequencer for the team's serial pattern-check datapath. Holds a programmable W-bit shift-register window, arms on a start handshake, and scans a frame of `frame_len` valid serial bits. Each masked pattern match in the frame produces a one-cycle `hit` pulse and a saturating match count. A `done` pulse closes the frame. It sits between the stimulus/serial front end and the result-collection logic, and replaces hard-wired fixed-pattern checkers.

## Interface
Parameters:
- `W`, default 7: pattern/window length in bits; W >= 2; W <= 2^CNTW - 1.
- `CNTW`, default 8: width of `frame_len` and the internal bit counter.
- `MW`, default 8: width of `match_cnt`.

Ports:
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `start`, input, 1: begin a frame; sampled only in IDLE.
- `pat`, input, W: pattern; latched on accepted `start`; `pat[0]` = newest bit, `pat[W-1]` = oldest.
- `mask`, input, W: compare enable per bit (1 = compare); latched with `pat`.
- `frame_len`, input, CNTW: number of valid bits in the frame; latched on `start`.
- `in`, input, 1: serial data bit.
- `in_vld`, input, 1: `in` is valid this cycle; ignored outside RUN.
- `busy`, output, 1: high in RUN and DONE.
- `done`, output, 1: one-cycle pulse at frame end.
- `hit`, output, 1: one-cycle pulse per match.
- `match_cnt`, output, MW: matches in current/last frame; saturates at 2^MW - 1.
- `overflow`, output, 1: sticky; set when a match occurs with `match_cnt` already saturated.

## Operation
- FSM states: IDLE, RUN, DONE.
- Reset (`rst`=1 at an edge): state IDLE. All of `busy`, `done`, `hit`, `match_cnt`, `overflow`, the history register, the bit counter and the latched config clear to 0. Reset overrides everything, including mid-frame.
- IDLE:
  - `start`=1: latch `pat`, `mask`, `frame_len`; clear history, bit counter, `match_cnt`, `overflow`.
  - Next state is RUN, or DONE if `frame_len` = 0.
- RUN, on each cycle with `in_vld`=1:
  - `hist <= {hist[W-2:0], in}`.
  - `bitcnt <= bitcnt + 1`.
  - Match test uses the post-shift window `{hist[W-2:0], in}`: match when `((window ^ pat_l) & mask_l) == 0` and `bitcnt + 1 >= W`.
  - On match: `hit` <= 1; `match_cnt` increments unless saturated; if already saturated, `overflow` <= 1.
  - Overlapping matches count individually.
  - If `bitcnt + 1 == frame_len_l`, next state is DONE.
- RUN with `in_vld`=0: no shift, no count, `hit` <= 0, state holds (stalls allowed indefinitely).
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` in RUN or DONE is ignored; it is not queued.
- `match_cnt` and `overflow` hold their final values in IDLE until the next accepted `start`.
- `mask` = 0: every valid bit from the W-th onward is a match.
- `frame_len` < W: frame completes with `match_cnt` = 0.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Start handshake:
  - `start` sampled at edge k in IDLE → `busy`=1 from edge k.
  - The first bit is accepted at edge k+1 at the earliest.
  - `frame_len` = 0 → `done` high in the cycle after edge k.
- Hit latency: bit sampled at edge n completes a match → `hit` high and `match_cnt` updated from edge n, for one cycle.
- Frame end:
  - The last bit is sampled at edge n, so state = DONE from edge n.
  - `done`=1 and `busy`=1 in the cycle after edge n, coincident with that bit's `hit` and final `match_cnt`.
  - `busy`=0 from edge n+1.
- Minimum `start`-to-`start` spacing: frame_len + 2 cycles, with in_vld held high.
- Throughput: one bit per cycle.

## Test plan
- Reset mid-frame: assert `rst` during RUN after 3 bits → next cycle all outputs 0, state IDLE; a subsequent `in_vld` has no effect.
- W=7, `pat`=7'b1010101, `mask`=7'h7F, `frame_len`=10, stream oldest-first 1,0,1,0,1,0,1,0,1,0 with `in_vld`=1 → `hit` after bits 7 and 9, `match_cnt`=2, `done` coincident with bit 10 result, `busy` low the following cycle.
- Same config with `in_vld` toggling 1,0 each cycle → identical hits/count; bits stretched over 20 cycles; no hit in stall cycles.
- `mask`=7'b1111110 (ignore newest bit), `pat`=7'b0101010, stream 0,1,0,1,0,1,1 then 0,1,0,1,0,1,0 (`frame_len`=14) → `match_cnt`=2, with hits on bits 7 and 14.
- MW=2, `mask`=0, `frame_len`=12 → matches on bits 7–12, `match_cnt`=3 saturated, `overflow`=1; both hold in IDLE and clear on next `start`.
- `frame_len`=0 → `done` one cycle after `start`, `match_cnt`=0. A `start` pulsed during RUN of a 10-bit frame is ignored, with no second `done`.
